// File: rtl/ram2_mem_arbiter.sv
// RAM2 port arbiter: MEM-stage accesses below RAM2_LIMIT pre-empt instruction fetch.
// Optional post-write recovery window is compiled in with `define RAM2_WR_RECOVERY_EN.
module ram2_mem_arbiter #(
  parameter logic [17:0] RAM2_LIMIT  = 18'h08000,
  parameter int unsigned WR_RECOVERY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_i,
  input  logic [17:0] mem_addr_i,
  input  logic [15:0] mem_wdata_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [15:0] ram2res_i,
  output logic        is_RAM2_mem_o,
  output logic [17:0] addr_mem_o,
  output logic [15:0] data_mem_o,
  output logic        isread_mem_o,
  output logic        iswrite_mem_o,
  output logic [15:0] addr_if_o,
  output logic [15:0] inst_o,
  output logic        inst_valid_o,
  output logic [15:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_RECOVER} state_t;

  state_t state_q, state_d;
  logic   mem_hit;
  logic   rec_done;
  logic   if_cycle;
  logic   mem_rd_cycle;
  logic   mem_cycle;

  // Both strobes high is treated as a malformed request and left to IF.
  assign mem_hit    = (mem_addr_i < RAM2_LIMIT) && (mem_read_i ^ mem_write_i);
  assign addr_if_o  = pc_i;
  assign addr_mem_o = mem_addr_i;
  assign data_mem_o = mem_wdata_i;

`ifdef RAM2_WR_RECOVERY_EN
  localparam bit REC_EN = (WR_RECOVERY != 32'd0);

  logic [1:0] rec_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_cnt <= '0;
    end else if (state_q == S_RUN && mem_hit && mem_write_i && REC_EN) begin
      rec_cnt <= 2'(WR_RECOVERY - 32'd1);
    end else if (state_q == S_RECOVER && rec_cnt != 2'd0) begin
      rec_cnt <= rec_cnt - 2'd1;
    end
  end

  assign rec_done = (rec_cnt == 2'd0);
`else
  // Recovery compiled out: WR_RECOVERY has no effect and S_RECOVER is unreachable.
  localparam bit REC_EN = 1'b0 && (WR_RECOVERY != 32'd0);

  assign rec_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:    state_d = S_RUN;
      S_RUN:     if (mem_hit && mem_write_i && REC_EN) state_d = S_RECOVER;
      S_RECOVER: if (rec_done) state_d = S_RUN;
      default:   state_d = S_INIT;
    endcase
  end

  // Outputs are also gated by rst so an in-flight write is dropped immediately.
  always_comb begin
    is_RAM2_mem_o = 1'b0;
    isread_mem_o  = 1'b0;
    iswrite_mem_o = 1'b0;
    stall_o       = 1'b1;
    if_cycle      = 1'b0;
    mem_rd_cycle  = 1'b0;
    mem_cycle     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_RUN: begin
          if (mem_hit) begin
            is_RAM2_mem_o = 1'b1;
            isread_mem_o  = mem_read_i;
            iswrite_mem_o = mem_write_i;
            mem_rd_cycle  = mem_read_i;
            mem_cycle     = 1'b1;
          end else begin
            stall_o  = 1'b0;
            if_cycle = 1'b1;
          end
        end
        S_RECOVER: is_RAM2_mem_o = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      mem_rdata_o  <= '0;
      mem_done_o   <= 1'b0;
    end else begin
      inst_valid_o <= if_cycle;
      mem_done_o   <= mem_cycle;
      if (if_cycle)     inst_o      <= ram2res_i;
      if (mem_rd_cycle) mem_rdata_o <= ram2res_i;
    end
  end

endmodule

// File: tb/tb_ram2_mem_arbiter.sv
// Scoreboard bench for ram2_mem_arbiter: per-cycle strobe checks plus queued
// expectations for the registered outputs, compared one cycle later.
module tb_ram2_mem_arbiter;

`ifdef RAM2_WR_RECOVERY_EN
  localparam int REC_CYCLES = 2;
`else
  localparam int REC_CYCLES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_i;
  logic [17:0] mem_addr_i;
  logic [15:0] mem_wdata_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [15:0] ram2res_i;
  logic        is_RAM2_mem_o;
  logic [17:0] addr_mem_o;
  logic [15:0] data_mem_o;
  logic        isread_mem_o;
  logic        iswrite_mem_o;
  logic [15:0] addr_if_o;
  logic [15:0] inst_o;
  logic        inst_valid_o;
  logic [15:0] mem_rdata_o;
  logic        mem_done_o;
  logic        stall_o;

  ram2_mem_arbiter #(.RAM2_LIMIT(18'h08000), .WR_RECOVERY(2)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .ram2res_i(ram2res_i), .is_RAM2_mem_o(is_RAM2_mem_o), .addr_mem_o(addr_mem_o),
    .data_mem_o(data_mem_o), .isread_mem_o(isread_mem_o), .iswrite_mem_o(iswrite_mem_o),
    .addr_if_o(addr_if_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] inst;
    logic        vld;
    logic [15:0] rdata;
    logic        done;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_inst;
  logic [15:0] model_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, ".inst"},  32'(inst_o),       32'(e.inst));
      chk({e.tag, ".vld"},   32'(inst_valid_o), 32'(e.vld));
      chk({e.tag, ".rdata"}, 32'(mem_rdata_o),  32'(e.rdata));
      chk({e.tag, ".done"},  32'(mem_done_o),   32'(e.done));
    end
  endtask

  // Called just after a rising edge with inputs already driven; returns just after the next one.
  task automatic step(input string tag, input bit e_stall, input bit e_mem,
                      input bit e_rd, input bit e_wr, input bit e_if);
    exp_t e;
    @(negedge clk);
    sb_pop();
    chk({tag, ".stall"},   32'(stall_o),       32'(e_stall));
    chk({tag, ".is_mem"},  32'(is_RAM2_mem_o), 32'(e_mem));
    chk({tag, ".isread"},  32'(isread_mem_o),  32'(e_rd));
    chk({tag, ".iswrite"}, 32'(iswrite_mem_o), 32'(e_wr));
    chk({tag, ".addr_if"}, 32'(addr_if_o),     32'(pc_i));
    if (e_rd || e_wr) begin
      chk({tag, ".addr_mem"}, 32'(addr_mem_o), 32'(mem_addr_i));
      chk({tag, ".data_mem"}, 32'(data_mem_o), 32'(mem_wdata_i));
    end
    if (e_if) model_inst  = ram2res_i;
    if (e_rd) model_rdata = ram2res_i;
    e.tag   = tag;
    e.inst  = model_inst;
    e.vld   = e_if;
    e.rdata = model_rdata;
    e.done  = e_rd | e_wr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] pc, input logic [17:0] addr, input logic rd,
                       input logic wr, input logic [15:0] wdata, input logic [15:0] res);
    pc_i = pc; mem_addr_i = addr; mem_read_i = rd; mem_write_i = wr;
    mem_wdata_i = wdata; ram2res_i = res;
  endtask

  task automatic reset_model();
    sb_q.delete();
    model_inst  = '0;
    model_rdata = '0;
  endtask

  initial begin
    reset_model();
    rst = 1'b1;
    drive(16'h0010, 18'h00000, 1'b0, 1'b0, 16'h0000, 16'hA5A5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.stall",   32'(stall_o),       32'd1);
    chk("rst.isread",  32'(isread_mem_o),  32'd0);
    chk("rst.iswrite", 32'(iswrite_mem_o), 32'd0);
    chk("rst.inst",    32'(inst_o),        32'h0);
    chk("rst.vld",     32'(inst_valid_o),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    step("init",  1, 0, 0, 0, 0);
    step("fetch", 0, 0, 0, 0, 1);

    drive(16'h0011, 18'h00100, 1'b1, 1'b0, 16'h0000, 16'h1234);
    step("rd",    1, 1, 1, 0, 0);
    drive(16'h0011, 18'h00000, 1'b0, 1'b0, 16'h0000, 16'h5678);
    step("fetch2", 0, 0, 0, 0, 1);

    drive(16'h0012, 18'h00101, 1'b1, 1'b0, 16'h0000, 16'h1111);
    step("b2b0",  1, 1, 1, 0, 0);
    drive(16'h0012, 18'h00102, 1'b1, 1'b0, 16'h0000, 16'h2222);
    step("b2b1",  1, 1, 1, 0, 0);
    drive(16'h0012, 18'h00000, 1'b0, 1'b0, 16'h0000, 16'h3333);
    step("fetch3", 0, 0, 0, 0, 1);

    drive(16'h0013, 18'h00200, 1'b0, 1'b1, 16'hBEEF, 16'h0BAD);
    step("wr",    1, 1, 0, 1, 0);
    drive(16'h0013, 18'h00000, 1'b0, 1'b0, 16'h0000, 16'h0BAD);
    for (int i = 0; i < REC_CYCLES; i++) step("rec", 1, 1, 0, 0, 0);
    drive(16'h0013, 18'h00000, 1'b0, 1'b0, 16'h0000, 16'h4444);
    step("resume", 0, 0, 0, 0, 1);

    drive(16'h0014, 18'h08000, 1'b1, 1'b0, 16'h0000, 16'h5555);
    step("limit", 0, 0, 0, 0, 1);
    drive(16'h0015, 18'h07FFF, 1'b1, 1'b0, 16'h0000, 16'h6666);
    step("below", 1, 1, 1, 0, 0);
    drive(16'h0016, 18'h00050, 1'b1, 1'b1, 16'h7777, 16'h8888);
    step("both",  0, 0, 0, 0, 1);
    drive(16'h0017, 18'h00000, 1'b0, 1'b0, 16'h0000, 16'h9999);
    step("fetch4", 0, 0, 0, 0, 1);

    // Abort a write with reset mid-cycle.
    drive(16'h0018, 18'h00300, 1'b0, 1'b1, 16'hCAFE, 16'h0000);
    @(negedge clk);
    sb_pop();
    chk("abort.pre_wr", 32'(iswrite_mem_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort.iswrite", 32'(iswrite_mem_o), 32'd0);
    chk("abort.stall",   32'(stall_o),       32'd1);
    chk("abort.is_mem",  32'(is_RAM2_mem_o), 32'd0);
    chk("abort.inst",    32'(inst_o),        32'h0);
    chk("abort.vld",     32'(inst_valid_o),  32'd0);
    chk("abort.rdata",   32'(mem_rdata_o),   32'h0);
    chk("abort.done",    32'(mem_done_o),    32'd0);
    reset_model();
    @(posedge clk); #1;
    rst = 1'b0;
    drive(16'h0020, 18'h00000, 1'b0, 1'b0, 16'h0000, 16'hD00D);
    step("init2",  1, 0, 0, 0, 0);
    step("fetch5", 0, 0, 0, 0, 1);
    @(negedge clk);
    sb_pop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram2_mem_arbiter.md
# ram2_mem_arbiter

- Shares the single RAM2 port between instruction fetch (IF) and the MEM stage, and sits directly upstream of the RAM2 interface block.
- MEM accesses that decode to RAM2 take priority; IF is stalled while they run.
- After a write, the block holds an optional recovery window before fetch resumes.
- Read data from the RAM2 interface is registered and returned as the instruction or as MEM load data.

## Interface
- `RAM2_LIMIT`, default 18'h08000: MEM addresses strictly below this value target RAM2.
- `WR_RECOVERY`, default 1: number of idle cycles after a RAM2 write (0–3).
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_i` in 16: fetch address.
- `mem_addr_i` in 18: MEM-stage address.
- `mem_wdata_i` in 16: store data.
- `mem_read_i` in 1: MEM load request.
- `mem_write_i` in 1: MEM store request.
- `ram2res_i` in 16: data captured by the RAM2 interface on the falling clock edge.
- `is_RAM2_mem_o` out 1: MEM owns RAM2 this cycle.
- `addr_mem_o` out 18: RAM2 address for the MEM path.
- `data_mem_o` out 16: RAM2 write data.
- `isread_mem_o` out 1: RAM2 read strobe (MEM path).
- `iswrite_mem_o` out 1: RAM2 write strobe (MEM path).
- `addr_if_o` out 16: RAM2 fetch address.
- `inst_o` out 16: registered instruction.
- `inst_valid_o` out 1: `inst_o` was fetched in the previous cycle.
- `mem_rdata_o` out 16: registered load data.
- `mem_done_o` out 1: one-cycle pulse marking completion of a MEM access.
- `stall_o` out 1: freeze PC and IF/ID this cycle.

## Operation
- A MEM hit requires `mem_addr_i < RAM2_LIMIT` and exactly one of `mem_read_i` / `mem_write_i`.
- If both strobes are high, the request is ignored: IF owns the port, no `mem_done_o`.
- FSM states: `S_INIT`, `S_RUN`, `S_RECOVER`.
- `S_INIT`: entered on reset.
  - Lasts one cycle; no port owner, `stall_o`=1.
  - Moves to `S_RUN`.
- `S_RUN`, MEM hit:
  - MEM owns the port: `is_RAM2_mem_o`=1, `addr_mem_o`=`mem_addr_i`, strobes passed through, `stall_o`=1.
  - A write with recovery enabled and `WR_RECOVERY`>0 moves to `S_RECOVER` and loads the counter with `WR_RECOVERY`-1.
  - Otherwise the state stays in `S_RUN`.
- `S_RUN`, no MEM hit:
  - IF owns the port: `is_RAM2_mem_o`=0, `addr_if_o`=`pc_i`, `stall_o`=0.
- `S_RECOVER`:
  - `is_RAM2_mem_o`=1 with both strobes at 0 (idle read, result discarded); `stall_o`=1.
  - A new MEM hit is not accepted; MEM must hold its request.
  - The 2-bit counter decrements each cycle; when it reaches 0 the state returns to `S_RUN`.
- `addr_if_o` = `pc_i` at all times.
- `data_mem_o` = `mem_wdata_i` at all times.
- All strobes are forced to 0 outside `S_RUN`.
- Registered on every rising edge:
  - IF cycle: `inst_o`←`ram2res_i`, `inst_valid_o`←1.
  - Any other cycle: `inst_o` holds, `inst_valid_o`←0.
  - MEM read cycle: `mem_rdata_o`←`ram2res_i`.
  - MEM read or write cycle: `mem_done_o`←1 for one cycle.
- Reset values: `inst_o`=16'h0000, `inst_valid_o`=0, `mem_rdata_o`=16'h0000, `mem_done_o`=0, state=`S_INIT`, counter=0.
- During reset, `stall_o`=1 and all strobes are 0.

## Timing
- Access in cycle N:
  - The RAM2 block samples data on the falling edge in N.
  - This block registers it on the rising edge ending N.
  - `inst_o` / `mem_rdata_o` / `mem_done_o` are valid in N+1.
- `stall_o` is combinational and valid in the same cycle as the conflict.
- A MEM hit costs IF exactly 1 cycle. A write additionally costs `WR_RECOVERY` cycles.
- Back-to-back MEM reads in `S_RUN` are accepted every cycle; IF stays stalled throughout.
- Asserting `rst` mid-access drops all strobes immediately (the write is aborted).
- After reset release there is 1 init cycle; the first fetch happens in the following cycle.

## Configuration
- `RAM2_WR_RECOVERY_EN` defined: `S_RECOVER` and the counter are compiled in and `WR_RECOVERY` applies.
- `RAM2_WR_RECOVERY_EN` undefined: writes return straight to `S_RUN`, `WR_RECOVERY` is ignored, and a store costs IF exactly 1 cycle.

## Test plan
- Reset release, `pc_i`=16'h0010, `ram2res_i`=16'hA5A5, no MEM request:
  - `stall_o`=1 in the first cycle.
  - Cycle 2 fetches; in cycle 3 `inst_o`=16'hA5A5, `inst_valid_o`=1.
- MEM read at 18'h00100, `ram2res_i`=16'h1234:
  - `stall_o`=1 and `is_RAM2_mem_o`=1 that cycle.
  - Next cycle `mem_rdata_o`=16'h1234, `mem_done_o`=1, `inst_valid_o`=0, `inst_o` unchanged.
- MEM write 16'hBEEF to 18'h00200, `WR_RECOVERY`=2, macro defined:
  - `iswrite_mem_o`=1 for 1 cycle, then 2 idle cycles with strobes at 0 and `stall_o`=1.
  - Fetch resumes in cycle 4.
  - With the macro undefined, fetch resumes in cycle 2.
- MEM read at 18'h08000 (equal to `RAM2_LIMIT`): not a hit; IF owns the port, `stall_o`=0, no `mem_done_o`.
- `mem_read_i`=`mem_write_i`=1 at 18'h00050: ignored; IF fetches, `mem_done_o` stays 0.
- `rst` asserted during a write cycle: `iswrite_mem_o` drops to 0 at once; all registered outputs go to 0 and the state returns to `S_INIT`.
